dmux4way_sched: RTL and testbench
=================================

# dmux4way_sched

Round-robin / addressed scheduler that sequences the existing `dmux4way` demultiplexer. It accepts words from a single upstream valid/ready source, holds each in a one-entry register, and drives `sel` so the word reaches exactly one of four downstream consumers. Each consumer has its own ready. In round-robin mode a consumer stalled for `TIMEOUT` cycles is skipped. The block sits between the producer and the `dmux4way` fan-out, which it instantiates.

## Interface
Parameters:
- `WIDTH`, 4: data word width, matching the `dmux4way` `entrada` width.
- `TIMEOUT`, 8: consecutive stalled SEND cycles before a round-robin reroute; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  upstream word.
- `in_dest`  in  2  target output; used only in addressed mode.
- `modo`  in  1  0 = round-robin, 1 = addressed; sampled at accept.
- `out_valid`  out  4  one-hot valid; bit i goes to consumer i (o0..o3).
- `out_ready`  in  4  per-consumer ready.
- `out_data`  out  WIDTH  held word, shared by all consumers.
- `sel`  out  2  current target index.
- `reroute`  out  1  one-cycle pulse when a timeout skips a consumer.

## Operation
- States: IDLE and SEND.
- IDLE:
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid`: latch `in_data` and `modo`; `target` = `modo ? in_dest : rr_ptr`; go to SEND.
- SEND:
  - `in_ready` = 0; `out_valid[target]` = 1, other bits 0; `sel` = `target`; `out_data` = held word.
  - If `out_ready[target]`: word delivered. In round-robin mode `rr_ptr` = `target`+1 (mod 4; 3 wraps to 0). Go to IDLE.
  - Else, round-robin mode: `wait_cnt`+1. When `wait_cnt` = `TIMEOUT`-1: `target` = `target`+1 (mod 4), `wait_cnt` = 0, pulse `reroute`.
  - Else, addressed mode: wait indefinitely. No timeout and no reroute.
- `out_ready` bits for non-targeted outputs are ignored.
- `modo` changes during SEND have no effect; the latched mode governs the word.
- A successful reroute delivery advances `rr_ptr` from the final `target`, not the original one.
- `wait_cnt` clears on every entry to SEND.

## Timing
- Reset (async assert) forces the following; release takes effect on the next edge:
  - state = IDLE, so `in_ready` = 1;
  - `out_valid` = 0, `out_data` = 0, `sel` = 0, `reroute` = 0;
  - `rr_ptr` = 0, `wait_cnt` = 0.
- Accept edge: `in_valid` && `in_ready`. `out_valid`, `sel` and `out_data` are valid from the next cycle (latency 1).
- Deliver edge: `out_valid[i]` && `out_ready[i]`. `in_ready` = 1 the next cycle.
- Peak throughput is one word per 2 cycles. There is no same-cycle accept-and-deliver.
- Timeout: with `out_ready[target]` continuously low, `sel` changes after exactly `TIMEOUT` SEND cycles. `reroute` is high in the cycle the new `sel` is first visible.
- If `out_ready[target]` rises in the timeout cycle, delivery wins: no reroute, and `rr_ptr` advances normally.
- Reset asserted in SEND discards the held word; no `out_valid` pulse follows.
- All outputs are registered or decoded from registered state. There is no combinational path from `out_ready` or `in_valid` to any output.

## Structure
- Shared include `dmux4way_defs.vh` holds:
  - state encodings (`ST_IDLE` = 1'b0, `ST_SEND` = 1'b1);
  - output index constants `SEL_O0`..`SEL_O3` (2'd0..2'd3).
- Instantiate `dmux4way` as the sub-module that builds `out_valid`:
  - `entrada` = {3'b000, state==SEND};
  - `sel` = `target`;
  - `o0`..`o3` map to `out_valid[0]`..`[3]`.
- Controller: FSM, `target`, `rr_ptr`, 4-bit `wait_cnt` and the data holding register, all in one module.

## Test plan
- Reset, round-robin, all `out_ready` = 4'b1111, send 4'h1, 4'h2, 4'h3, 4'h4, 4'h5 back-to-back:
  - `sel` sequence 0,1,2,3,0;
  - each word appears on `out_data` one cycle after accept;
  - `in_ready` toggles 1/0 each cycle.
- Addressed mode, `in_dest` = 2, `out_ready` = 4'b0000 for 20 cycles, then 4'b0100:
  - `out_valid` = 4'b0100 throughout, `reroute` never pulses;
  - delivery on the first ready cycle.
- Round-robin, `TIMEOUT` = 8, `rr_ptr` = 1, `out_ready` = 4'b1101:
  - `out_valid` 4'b0010 for 8 cycles, then 4'b0100 with a `reroute` pulse;
  - delivery to o2, after which `rr_ptr` = 3.
- Round-robin, `out_ready[target]` rises exactly in the 8th stall cycle:
  - delivery, no `reroute`, `sel` unchanged until IDLE.
- Reset asserted mid-SEND (`out_valid` = 4'b1000):
  - all outputs go to reset values immediately;
  - after release, the next word goes to o0.
- `modo` toggled 0→1 during SEND:
  - the held word still follows round-robin/timeout rules;
  - the next accepted word uses `in_dest`.

Source files
------------

// File: rtl/dmux4way_sched_pkg.sv
// Shared types and constants for the dmux4way scheduler slice.
package dmux4way_sched_pkg;

  // Controller states: IDLE accepts a word, SEND offers it downstream.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Output index constants, one per downstream consumer.
  localparam logic [1:0] SEL_O0 = 2'd0;
  localparam logic [1:0] SEL_O1 = 2'd1;
  localparam logic [1:0] SEL_O2 = 2'd2;
  localparam logic [1:0] SEL_O3 = 2'd3;

  // Width of the stall counter; covers TIMEOUT values 1..15.
  localparam int unsigned WAIT_W = 4;

  // Next consumer in round-robin order; 3 wraps back to 0.
  function automatic logic [1:0] next_index(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/dmux4way_sched_dmux4way.sv
// 1-to-4 demultiplexer: routes entrada to the output chosen by sel,
// all other outputs are driven to zero.
module dmux4way
  import dmux4way_sched_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] entrada,
  input  logic [1:0]   sel,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3
);

  // Steer the input word onto exactly one output.
  always_comb begin
    o0 = '0;
    o1 = '0;
    o2 = '0;
    o3 = '0;
    case (sel)
      SEL_O0:  o0 = entrada;
      SEL_O1:  o1 = entrada;
      SEL_O2:  o2 = entrada;
      SEL_O3:  o3 = entrada;
      default: o0 = '0;
    endcase
  end

endmodule

// File: rtl/dmux4way_sched.sv
// Scheduler in front of a dmux4way fan-out: takes one word at a time from
// a valid/ready producer, holds it, and offers it to one of four consumers.
// Round-robin words skip a consumer that stalls for TIMEOUT SEND cycles;
// addressed words wait on their consumer indefinitely.
module dmux4way_sched
  import dmux4way_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             modo,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic             reroute
);

  // Stall count at which the current consumer is abandoned.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t             state_r;
  logic [1:0]         target_r;
  logic [1:0]         rr_ptr_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [WIDTH-1:0]   data_r;
  logic               mode_r;
  logic               reroute_r;

  logic               send_s;
  logic [3:0]         entrada_s;
  logic [3:0]         o0_s;
  logic [3:0]         o1_s;
  logic [3:0]         o2_s;
  logic [3:0]         o3_s;

  // Controller FSM: accept, hold, deliver, and round-robin timeout skip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      target_r   <= SEL_O0;
      rr_ptr_r   <= SEL_O0;
      wait_cnt_r <= '0;
      data_r     <= '0;
      mode_r     <= 1'b0;
      reroute_r  <= 1'b0;
    end else begin
      reroute_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_r     <= in_data;
            mode_r     <= modo;
            target_r   <= modo ? in_dest : rr_ptr_r;
            wait_cnt_r <= '0;
            state_r    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready[target_r]) begin
            // Delivery wins over a coincident timeout.
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            if (!mode_r) begin
              rr_ptr_r <= next_index(target_r);
            end
          end else if (!mode_r) begin
            if (wait_cnt_r == WAIT_LAST) begin
              target_r   <= next_index(target_r);
              wait_cnt_r <= '0;
              reroute_r  <= 1'b1;
            end else begin
              wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded controls into the fan-out; only bit 0 of entrada carries valid.
  always_comb begin
    send_s    = (state_r == ST_SEND);
    entrada_s = {3'b000, send_s};
  end

  dmux4way #(
    .W (4)
  ) u_dmux (
    .entrada (entrada_s),
    .sel     (target_r),
    .o0      (o0_s),
    .o1      (o1_s),
    .o2      (o2_s),
    .o3      (o3_s)
  );

  // Upper dmux bits are always zero, so OR-reducing equals bit 0.
  always_comb begin
    out_valid = {|o3_s, |o2_s, |o1_s, |o0_s};
  end

  // Remaining outputs come straight from registered state.
  always_comb begin
    in_ready = (state_r == ST_IDLE);
    out_data = data_r;
    sel      = target_r;
    reroute  = reroute_r;
  end

endmodule

// File: tb/tb_dmux4way_sched.sv
// Self-checking bench for dmux4way_sched: directed scenarios plus a random
// phase compared against a transaction-level model of the scheduler rules.
module tb_dmux4way_sched;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             modo;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic             reroute;

  int checks;
  int failures;

  // Reference model: one pending word, its consumer, stall count, rr pointer.
  bit               m_busy;
  int               m_tgt;
  int               m_rr;
  int               m_stall;
  logic [WIDTH-1:0] m_word;
  bit               m_mode;
  bit               m_reroute;

  dmux4way_sched #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .modo      (modo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .reroute   (reroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_busy = 0; m_tgt = 0; m_rr = 0; m_stall = 0;
    m_word = '0; m_mode = 0; m_reroute = 0;
  endtask

  // Apply one clock edge to the model using the inputs now on the pins.
  task automatic model_step();
    m_reroute = 0;
    if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_word = in_data; m_mode = modo;
        m_tgt = modo ? int'(in_dest) : m_rr;
        m_stall = 0;
      end
    end else if (out_ready[m_tgt]) begin
      m_busy = 0;
      if (!m_mode) m_rr = (m_tgt + 1) % 4;
    end else if (!m_mode) begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        m_tgt = (m_tgt + 1) % 4; m_stall = 0; m_reroute = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = '0; in_dest = 2'd0; modo = 0; out_ready = 4'b0000;
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000 || out_data !== 4'h0 ||
        sel !== 2'd0 || reroute !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h sel=%0d reroute=%b expected 1 0000 0 0 0",
               in_ready, out_valid, out_data, sel, reroute);
    end
  endtask

  task automatic test_back_to_back();
    modo = 0; out_ready = 4'b1111; in_valid = 1;
    for (int k = 1; k <= 5; k++) begin
      in_data = WIDTH'(k);
      tick();
      checks++;
      if (sel !== 2'((k - 1) % 4) || out_data !== WIDTH'(k) || in_ready !== 1'b0 ||
          out_valid !== (4'b0001 << ((k - 1) % 4))) begin
        failures++;
        $display("FAIL b2b_send word %0d: sel=%0d out_data=%h in_ready=%b out_valid=%b expected sel=%0d",
                 k, sel, out_data, in_ready, out_valid, (k - 1) % 4);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
        failures++;
        $display("FAIL b2b_idle word %0d: in_ready=%b out_valid=%b expected 1 0000", k, in_ready, out_valid);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_addressed_stall();
    modo = 1; in_dest = 2'd2; in_data = 4'hA; out_ready = 4'b0000; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 4'b0100 || reroute !== 1'b0) begin
        failures++;
        $display("FAIL addr_hold cycle %0d: out_valid=%b reroute=%b expected 0100 0", i, out_valid, reroute);
      end
      tick();
    end
    out_ready = 4'b0100;
    checks++;
    if (out_valid !== 4'b0100 || out_data !== 4'hA) begin
      failures++;
      $display("FAIL addr_last: out_valid=%b out_data=%h expected 0100 a", out_valid, out_data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL addr_deliver: in_ready=%b out_valid=%b expected 1 0000", in_ready, out_valid);
    end
    out_ready = 4'b0000;
  endtask

  task automatic test_timeout_reroute();
    // rr_ptr is 1 here after five round-robin deliveries.
    modo = 0; in_data = 4'h7; out_ready = 4'b1101; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checks++;
      if (out_valid !== 4'b0010 || reroute !== 1'b0) begin
        failures++;
        $display("FAIL tmo_stall cycle %0d: out_valid=%b reroute=%b expected 0010 0", i, out_valid, reroute);
      end
      tick();
    end
    checks++;
    if (out_valid !== 4'b0100 || reroute !== 1'b1 || sel !== 2'd2) begin
      failures++;
      $display("FAIL tmo_reroute: out_valid=%b reroute=%b sel=%0d expected 0100 1 2", out_valid, reroute, sel);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || reroute !== 1'b0) begin
      failures++;
      $display("FAIL tmo_deliver: in_ready=%b reroute=%b expected 1 0", in_ready, reroute);
    end
    out_ready = 4'b1111; in_valid = 1; in_data = 4'h8;
    tick();
    in_valid = 0;
    checks++;
    if (sel !== 2'd3 || out_valid !== 4'b1000) begin
      failures++;
      $display("FAIL tmo_rr_next: sel=%0d out_valid=%b expected 3 1000", sel, out_valid);
    end
    tick();
  endtask

  task automatic test_ready_at_timeout();
    // rr_ptr is 0 here.
    modo = 0; in_data = 4'h3; out_ready = 4'b0000; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
    end
    out_ready = 4'b0001;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000 || reroute !== 1'b0 || sel !== 2'd0) begin
      failures++;
      $display("FAIL race_deliver: in_ready=%b out_valid=%b reroute=%b sel=%0d expected 1 0000 0 0",
               in_ready, out_valid, reroute, sel);
    end
    out_ready = 4'b1111; in_valid = 1; in_data = 4'h4;
    tick();
    in_valid = 0;
    checks++;
    if (sel !== 2'd1) begin
      failures++;
      $display("FAIL race_rr_next: sel=%0d expected 1", sel);
    end
    tick();
  endtask

  task automatic test_reset_mid_send();
    modo = 1; in_dest = 2'd3; in_data = 4'hC; out_ready = 4'b0000; in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 4'b1000) begin
      failures++;
      $display("FAIL mid_pre: out_valid=%b expected 1000", out_valid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000 || out_data !== 4'h0 ||
        sel !== 2'd0 || reroute !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: in_ready=%b out_valid=%b out_data=%h sel=%0d reroute=%b expected 1 0000 0 0 0",
               in_ready, out_valid, out_data, sel, reroute);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mid_no_pulse: out_valid=%b expected 0000", out_valid);
    end
    modo = 0; in_valid = 1; in_data = 4'h5;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 4'b0001 || out_data !== 4'h5) begin
      failures++;
      $display("FAIL mid_next_o0: out_valid=%b out_data=%h expected 0001 5", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_modo_toggle();
    // rr_ptr is 1 here.
    modo = 0; in_data = 4'h9; out_ready = 4'b0000; in_valid = 1;
    tick();
    in_valid = 0; modo = 1; in_dest = 2'd0;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
    end
    checks++;
    if (sel !== 2'd2 || reroute !== 1'b1 || out_valid !== 4'b0100) begin
      failures++;
      $display("FAIL modo_held_rr: sel=%0d reroute=%b out_valid=%b expected 2 1 0100", sel, reroute, out_valid);
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b1111; in_valid = 1; in_data = 4'hE;
    tick();
    in_valid = 0;
    checks++;
    if (sel !== 2'd0 || out_valid !== 4'b0001 || out_data !== 4'hE) begin
      failures++;
      $display("FAIL modo_next_addr: sel=%0d out_valid=%b out_data=%h expected 0 0001 e", sel, out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_valid;
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      in_dest   = 2'($urandom);
      modo      = ($urandom_range(0, 3) == 0);
      out_ready = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      tick();
      exp_valid = m_busy ? (4'b0001 << m_tgt) : 4'b0000;
      checks++;
      if (in_ready !== !m_busy || out_valid !== exp_valid || sel !== 2'(m_tgt) ||
          out_data !== m_word || reroute !== m_reroute) begin
        failures++;
        $display("FAIL rand cycle %0d: rdy=%b vld=%b sel=%0d data=%h rr=%b expected %b %b %0d %h %b",
                 n, in_ready, out_valid, sel, out_data, reroute,
                 !m_busy, exp_valid, m_tgt, m_word, m_reroute);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_addressed_stall();
    test_timeout_reroute();
    test_ready_at_timeout();
    test_reset_mid_send();
    test_modo_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
